// File: rtl/instruction_sequencer.sv
// instruction_sequencer: loadable program store that steps a PC and feeds {opcode,operand} to IF.
// Optional build macro SEQ_LOOP_EN: running off the end (or branching out of range) wraps to pc 0.
module instruction_sequencer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_en,
    input  logic          load_valid,
    input  logic [5:0]    load_data,
    output logic          load_ready,
    input  logic          init_regs,
    input  logic          halt_if,
    input  logic          branch_valid,
    input  logic [AW-1:0] branch_target,
    output logic [2:0]    opcode,
    output logic [2:0]    operand,
    output logic [AW-1:0] pc,
    output logic [AW:0]   prog_len,
    output logic          done
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d, prog_len_q, prog_len_d;
    logic [5:0]    ins_q, ins_d;
    logic [5:0]    mem_q [DEPTH];
    logic          beat;
    logic [AW:0]   pc_inc;

    assign load_ready = (state_q == LOAD) && (wr_ptr_q < (AW+1)'(DEPTH));
    assign beat       = load_ready && load_valid;
    assign pc_inc     = {1'b0, pc_q} + (AW+1)'(1);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        wr_ptr_d   = beat ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
        prog_len_d = prog_len_q;
        case (state_q)
            IDLE: begin
                if (load_en) begin
                    state_d  = LOAD;
                    pc_d     = '0;
                    wr_ptr_d = '0;
                end else if (!init_regs && prog_len_q != '0) begin
                    state_d = RUN;
                    pc_d    = '0;
                end
            end
            LOAD: begin
                if (!load_en) begin
                    state_d    = IDLE;
                    prog_len_d = wr_ptr_d;
                end
            end
            default: begin
                if (load_en) begin
                    state_d  = LOAD;
                    pc_d     = '0;
                    wr_ptr_d = '0;
                end else if (state_q == RUN) begin
                    // a redirect beats any stall; running past the end or out of range exits or wraps
                    if (branch_valid) begin
                        if ({1'b0, branch_target} < prog_len_q) pc_d = branch_target;
`ifdef SEQ_LOOP_EN
                        else pc_d = '0;
`else
                        else state_d = DONE;
`endif
                    end else if (!(halt_if || init_regs)) begin
                        if (pc_inc < prog_len_q) pc_d = pc_inc[AW-1:0];
`ifdef SEQ_LOOP_EN
                        else pc_d = '0;
`else
                        else state_d = DONE;
`endif
                    end
                end
            end
        endcase
        ins_d = (state_d == RUN) ? mem_q[pc_d] : 6'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            wr_ptr_q   <= '0;
            prog_len_q <= '0;
            ins_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            wr_ptr_q   <= wr_ptr_d;
            prog_len_q <= prog_len_d;
            ins_q      <= ins_d;
        end
    end

    always_ff @(posedge clk) begin
        if (beat) mem_q[wr_ptr_q[AW-1:0]] <= load_data;
    end

    assign opcode   = ins_q[5:3];
    assign operand  = ins_q[2:0];
    assign pc       = pc_q;
    assign prog_len = prog_len_q;
    assign done     = (state_q == DONE);
endmodule
